// File: rtl/sdram_fb_reader.sv
// Frame-buffer reader: fetches one frame of 16-bit pixels from an SDRAM controller
// as 8-beat (128-bit) bursts and streams them out as a valid/ready pixel stream.
//
// Parameters:
//   BASE_ADDR   - host word address of pixel 0
//   FRAME_WORDS - pixels per frame (multiple of 8)
//   FIFO_BURSTS - burst FIFO depth in 128-bit entries (power of 2, >= 2)
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   frame_start          - pulse that (re)starts a frame fetch from BASE_ADDR
//   rd_addr, rd_enable   - read request to the controller ({bank, row, col})
//   rd_data, rd_ready    - burst return; beat 0 in [15:0]
//   busy                 - controller has accepted / is running a sequence
//   pix_data, pix_valid, pix_ready, pix_last - pixel stream
//   underflow_cnt        - only with FB_READER_UNDERFLOW_CNT_EN: saturating count of
//                          cycles the sink was ready but no pixel was available
// Optional feature macro: FB_READER_UNDERFLOW_CNT_EN
module sdram_fb_reader #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned FRAME_WORDS = 130560,
    parameter int unsigned FIFO_BURSTS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    output logic [23:0]  rd_addr,
    output logic         rd_enable,
    input  logic [127:0] rd_data,
    input  logic         rd_ready,
    input  logic         busy,
    output logic [15:0]  pix_data,
    output logic         pix_valid,
    input  logic         pix_ready,
`ifdef FB_READER_UNDERFLOW_CNT_EN
    output logic [15:0]  underflow_cnt,
`endif
    output logic         pix_last
);

    localparam int unsigned Bursts = FRAME_WORDS / 8;
    localparam int unsigned IW     = $clog2(Bursts + 1);
    localparam int unsigned PW     = $clog2(FRAME_WORDS);
    localparam int unsigned AW     = $clog2(FIFO_BURSTS);
    localparam int unsigned CW     = $clog2(FIFO_BURSTS + 1);

    localparam logic [IW-1:0] NumBursts  = IW'(Bursts);
    localparam logic [IW-1:0] LastBurst  = IW'(Bursts - 1);
    localparam logic [PW-1:0] LastPixel  = PW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] FifoDepth  = CW'(FIFO_BURSTS);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_DONE} state_e;

    state_e        state_q, state_d;
    logic          active_q, active_d;
    logic          flush_pend_q, flush_pend_d;
    logic [IW-1:0] issued_q, issued_d;
    logic [23:0]   addr_q, addr_d;

    logic [127:0]  mem_q [FIFO_BURSTS];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [2:0]    beat_q;
    logic [PW-1:0] pix_idx_q;

    logic         push, pop, xfer;
    logic [127:0] head;

    // Beats are served straight from the FIFO head, so the burst being unpacked
    // still occupies its FIFO slot and counts against FIFO_BURSTS.
    assign head      = mem_q[rd_ptr_q];
    assign pix_valid = active_q && (count_q != '0);
    assign pix_data  = pix_valid ? head[{beat_q, 4'b0000} +: 16] : 16'h0000;
    assign pix_last  = pix_valid && (pix_idx_q == LastPixel);
    assign xfer      = pix_valid && pix_ready;
    assign pop       = xfer && (beat_q == 3'd7);
    // Data for a read overtaken by frame_start is dropped.
    assign push      = (state_q == R_WAIT) && rd_ready && !flush_pend_q && !frame_start;

    assign rd_enable = (state_q == R_REQ);
    assign rd_addr   = addr_q;

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        flush_pend_d = flush_pend_q;
        issued_d     = issued_q;
        addr_d       = addr_q;
        // The frame ends once its final pixel has been accepted.
        if (xfer && pix_last) active_d = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (!frame_start && active_q && (issued_q < NumBursts) &&
                    (count_q < FifoDepth) && !flush_pend_q) begin
                    state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (frame_start) flush_pend_d = 1'b1;
                if (busy) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (frame_start) flush_pend_d = 1'b1;
                if (rd_ready && !flush_pend_q && !frame_start) begin
                    addr_d   = addr_q + 24'd8;
                    issued_d = issued_q + IW'(1);
                    state_d  = (issued_q == LastBurst) ? R_DONE : R_IDLE;
                end
            end
            default: ;
        endcase
        // Restart now if no read is in flight, or once the in-flight read finishes.
        if ((frame_start && (state_q == R_IDLE || state_q == R_DONE)) ||
            (state_q == R_WAIT && rd_ready && (flush_pend_q || frame_start))) begin
            state_d      = R_IDLE;
            addr_d       = BASE_ADDR;
            issued_d     = '0;
            flush_pend_d = 1'b0;
        end
        if (frame_start) active_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= R_IDLE;
            active_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            issued_q     <= '0;
            addr_q       <= BASE_ADDR;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            flush_pend_q <= flush_pend_d;
            issued_q     <= issued_d;
            addr_q       <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            beat_q    <= '0;
            pix_idx_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (xfer) begin
                beat_q    <= beat_q + 3'd1;
                pix_idx_q <= pix_idx_q + PW'(1);
            end
        end
    end

`ifdef FB_READER_UNDERFLOW_CNT_EN
    logic [15:0] uf_q;

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            uf_q <= '0;
        end else if (active_q && pix_ready && !pix_valid && (uf_q != 16'hFFFF)) begin
            uf_q <= uf_q + 16'd1;
        end
    end

    assign underflow_cnt = uf_q;
`endif

endmodule

// File: tb/tb_sdram_fb_reader.sv
// Self-checking bench for sdram_fb_reader: a behavioural SDRAM controller with
// configurable refresh stall and latency, a pixel sink with selectable ready
// pattern, and a frame model that derives every pixel from its host address.
`timescale 1ns/1ps
module tb_sdram_fb_reader;

    localparam logic [23:0] BASE = 24'h000100;
    localparam int FW = 64;
    localparam int NB = FW / 8;
    localparam int FB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic [23:0]  rd_addr;
    logic         rd_enable;
    logic [127:0] rd_data = '0;
    logic         rd_ready = 1'b0;
    logic         busy = 1'b0;
    logic [15:0]  pix_data;
    logic         pix_valid;
    logic         pix_ready = 1'b0;
    logic         pix_last;
`ifdef FB_READER_UNDERFLOW_CNT_EN
    logic [15:0]  underflow_cnt;
`endif

    sdram_fb_reader #(
        .BASE_ADDR  (BASE),
        .FRAME_WORDS(FW),
        .FIFO_BURSTS(FB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .rd_addr      (rd_addr),
        .rd_enable    (rd_enable),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .busy         (busy),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
`ifdef FB_READER_UNDERFLOW_CNT_EN
        .underflow_cnt(underflow_cnt),
`endif
        .pix_last     (pix_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: content of a host word depends on its address and a per-frame seed.
    function automatic logic [15:0] pix_word(input logic [23:0] a, input logic [15:0] s);
        logic [31:0] t;
        t = {8'h00, a} * 32'd40503 + {16'h0000, s};
        return t[15:0] ^ t[31:16];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Controller model state
    int          refresh_cyc = 0;
    int          lat = 10;
    int          n_reads = 0;
    logic [23:0] req_addr [$];
    int          req_cyc [$];
    int          rdy_q [$];
    logic [23:0] exp_addr = BASE;
    logic [15:0] seed = 16'h0000;
    bit          discard = 0;
    bit          ctl_busy = 0;
    bit          in_wait = 0;

    initial begin : ctl
        logic [23:0] a;
        logic [15:0] s;
        int held;
        forever begin
            @(posedge clk); #1;
            if (!rst && rd_enable) begin
                a = rd_addr;
                s = seed;
                ctl_busy = 1;
                n_reads++;
                req_addr.push_back(a);
                req_cyc.push_back(cyc);
                check("req_addr", a, exp_addr);
                held = 0;
                for (int i = 0; i < refresh_cyc; i++) begin
                    @(posedge clk); #1;
                    if (rd_enable && rd_addr == a) held++;
                end
                check("req_hold", held, refresh_cyc);
                @(negedge clk);
                busy = 1'b1;
                @(posedge clk); #1;
                in_wait = 1;
                check("req_drop", rd_enable, 0);
                for (int i = 1; i < lat; i++) @(posedge clk);
                @(negedge clk);
                for (int b = 0; b < 8; b++) rd_data[16*b +: 16] = pix_word(a + 24'(b), s);
                rd_ready = 1'b1;
                rdy_q.push_back(cyc + 1);
                @(negedge clk);
                rd_ready = 1'b0;
                busy = 1'b0;
                if (discard) discard = 0;
                else exp_addr = a + 24'd8;
                in_wait = 0;
                ctl_busy = 0;
            end
        end
    end

    // Sink state: 0 = never ready, 1 = always ready, 2 = random
    int          sink_mode = 1;
    int          idx = FW;
    bit          restart = 0;
    logic [15:0] sink_seed = 16'h0000;
    int          pop_cyc = -1;
    int          restart_cyc = 0;
    int          first_v_cyc = -1;
    logic [15:0] uf_first = '0;
    logic [15:0] uf_restart = '0;

    initial begin : sink
        bit          prev_v = 0;
        bit          prev_r = 0;
        logic [15:0] prev_d = '0;
        bit          prev_l = 0;
        forever begin
            @(posedge clk); #1;
            if (prev_v && prev_r) begin
                check("pix_in_frame", idx < FW, 1);
                check("pix_data", prev_d, pix_word(BASE + 24'(idx), sink_seed));
                check("pix_last", prev_l, idx == FW - 1);
                if (idx == 7) pop_cyc = cyc;
                idx++;
            end
            if (restart) begin
                restart = 0;
                idx = 0;
                sink_seed = seed;
                restart_cyc = cyc;
                first_v_cyc = -1;
                check("flush_valid", pix_valid, 0);
`ifdef FB_READER_UNDERFLOW_CNT_EN
                uf_restart = underflow_cnt;
`endif
            end else begin
                if (prev_v && !prev_r) begin
                    check("hold_valid", pix_valid, 1);
                    check("hold_data", pix_data, prev_d);
                end
                if (idx == FW) check("idle_valid", pix_valid, 0);
                if (pix_valid && first_v_cyc < 0) begin
                    first_v_cyc = cyc;
`ifdef FB_READER_UNDERFLOW_CNT_EN
                    uf_first = underflow_cnt;
`endif
                end
            end
            prev_v = pix_valid;
            prev_d = pix_data;
            prev_l = pix_last;
            @(negedge clk);
            if (sink_mode == 2) pix_ready = ($urandom_range(0, 3) != 0);
            else pix_ready = (sink_mode == 1);
            prev_r = pix_ready;
        end
    end

    task automatic start_frame(input logic [15:0] s);
        @(negedge clk);
        seed = s;
        exp_addr = BASE;
        if (ctl_busy) discard = 1;
        n_reads = 0;
        req_addr.delete();
        req_cyc.delete();
        rdy_q.delete();
        pop_cyc = -1;
        frame_start = 1'b1;
        restart = 1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (idx < FW && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check(tag, idx, FW);
    endtask

    initial begin : main
        int n;
        // Reset, with frame_start asserted at the same time
        frame_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_enable", rd_enable, 0);
        check("rst_rd_addr", rd_addr, BASE);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_last", pix_last, 0);
`ifdef FB_READER_UNDERFLOW_CNT_EN
        check("rst_underflow", underflow_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        frame_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_frame", n_reads, 0);

        // Basic frame: always-ready sink, 10-cycle controller
        sink_mode = 1; lat = 10; refresh_cyc = 0;
        start_frame(16'h1234);
        wait_done("frame1_done", 2000);
        check("frame1_reads", n_reads, NB);
        check("frame1_addr0", req_addr[0], BASE);
        check("frame1_addr1", req_addr[1], BASE + 24'd8);
        check("start_to_req", req_cyc[0] - restart_cyc, 1);
        check("ready_to_valid", (first_v_cyc - rdy_q[0]) inside {[0:1]}, 1);
        check("frame1_idle_en", rd_enable, 0);

        // Refresh stall: request must be held 5 cycles
        refresh_cyc = 5;
        start_frame(16'h5A5A);
        wait_done("refresh_done", 3000);
        check("refresh_reads", n_reads, NB);
        refresh_cyc = 0;

        // Back-pressure: FIFO full blocks requests
        sink_mode = 0; lat = 6;
        start_frame(16'h0F0F);
        repeat (300) @(posedge clk);
        #1;
        check("full_reads", n_reads, FB);
        check("full_rd_enable", rd_enable, 0);
        sink_mode = 1;
        wait_done("full_done", 2000);
        check("full_pop_seen", pop_cyc >= 0, 1);
        check("fifth_after_pop", req_cyc[FB] > pop_cyc, 1);
        check("full_total", n_reads, NB);

        // Restart while a read is in R_WAIT
        sink_mode = 2; lat = 12;
        start_frame(16'hBEEF);
        n = 0;
        while (!(n_reads == 2 && in_wait) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_wait", n < 500, 1);
        repeat (3) @(posedge clk);
        start_frame(16'hC0DE);
        wait_done("flush_done", 4000);
        check("flush_addr0", req_addr[0], BASE);
        check("flush_reads", n_reads, NB);

        // Randomized frames
        for (int f = 0; f < 4; f++) begin
            lat = $urandom_range(3, 15);
            refresh_cyc = $urandom_range(0, 3);
            sink_mode = 1 + (f % 2);
            start_frame(16'($urandom));
            wait_done("rand_done", 5000);
            check("rand_reads", n_reads, NB);
        end
        refresh_cyc = 0;

`ifdef FB_READER_UNDERFLOW_CNT_EN
        // Underflow: first data about 20 cycles after frame_start, sink always ready
        sink_mode = 1; lat = 18;
        start_frame(16'h7777);
        wait_done("uf_done", 3000);
        check("uf_nonzero", uf_first != 0, 1);
        check("uf_stall", uf_first, first_v_cyc - restart_cyc);
        start_frame(16'h8888);
        check("uf_cleared", uf_restart, 0);
        wait_done("uf2_done", 3000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
